msrv32_wb_wr_en_pipe: RTL and testbench

//  Parametrised write-back commit stage. Registers NUM_CH write requests (integer RF, CSR, future FP/vector files)
//  and gates every write enable with flush, stall and a post-flush kill window.

---
 rtl/msrv32_wb_wr_en_pipe.sv | 110 +++++++++++
 tb/tb_msrv32_wb_wr_en_pipe.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/msrv32_wb_wr_en_pipe.sv
// Write-back commit stage: registers NUM_CH write requests and gates each write
// enable with flush, stall and a post-flush kill window; counts suppressed writes.
module msrv32_wb_wr_en_pipe #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int KILL_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     flush_in,
  input  logic                     stall_in,
  input  logic [NUM_CH-1:0]        wr_en_in,
  input  logic [NUM_CH*ADDR_W-1:0] wr_addr_in,
  input  logic [NUM_CH*DATA_W-1:0] wr_data_in,
  output logic [NUM_CH-1:0]        wr_en_out,
  output logic [NUM_CH*ADDR_W-1:0] wr_addr_out,
  output logic [NUM_CH*DATA_W-1:0] wr_data_out,
  output logic                     kill_active_out,
  output logic [CNT_W-1:0]         killed_cnt_out
);

  localparam int INC_W = $clog2(2 * NUM_CH + 1);
  localparam int SUM_W = CNT_W + INC_W;
  localparam logic [3:0]       KILL_LOAD = 4'(KILL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  function automatic logic [INC_W-1:0] popcount(input logic [NUM_CH-1:0] v);
    logic [INC_W-1:0] c;
    c = {INC_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      c = c + {{(INC_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  logic [NUM_CH-1:0]        vld_r;
  logic [NUM_CH*ADDR_W-1:0] addr_r;
  logic [NUM_CH*DATA_W-1:0] data_r;
  logic [3:0]               kill_cnt_r;
  logic                     kill_active_r;
  logic [CNT_W-1:0]         killed_cnt_r;

  logic [3:0]               kill_cnt_nxt_s;
  logic                     kill_idle_s;
  logic [INC_W-1:0]         inc_s;
  logic [SUM_W-1:0]         sum_s;
  logic [CNT_W-1:0]         killed_nxt_s;

  assign kill_idle_s     = (kill_cnt_r == 4'd0);
  assign wr_en_out       = vld_r & {NUM_CH{~(flush_in | stall_in)}};
  assign wr_addr_out     = addr_r;
  assign wr_data_out     = data_r;
  assign kill_active_out = kill_active_r;
  assign killed_cnt_out  = killed_cnt_r;

  // Kill window: a flush (re)loads the window, otherwise it drains even while stalled.
  always_comb begin
    kill_cnt_nxt_s = kill_cnt_r;
    if (flush_in) begin
      kill_cnt_nxt_s = KILL_LOAD;
    end else if (!kill_idle_s) begin
      kill_cnt_nxt_s = kill_cnt_r - 4'd1;
    end else begin
      kill_cnt_nxt_s = kill_cnt_r;
    end
  end

  // Suppressed writes: held valids lost to a flush plus fresh requests dropped by flush/kill.
  always_comb begin
    inc_s = popcount(vld_r & {NUM_CH{flush_in}})
          + popcount(wr_en_in & {NUM_CH{~stall_in & (flush_in | kill_active_r)}});
    sum_s = {{INC_W{1'b0}}, killed_cnt_r} + {{CNT_W{1'b0}}, inc_s};
    if (sum_s > {{INC_W{1'b0}}, CNT_MAX}) begin
      killed_nxt_s = CNT_MAX;
    end else begin
      killed_nxt_s = sum_s[CNT_W-1:0];
    end
  end

  // Stage registers: reset beats flush, flush beats stall, stall holds everything.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_r         <= {NUM_CH{1'b0}};
      addr_r        <= {(NUM_CH*ADDR_W){1'b0}};
      data_r        <= {(NUM_CH*DATA_W){1'b0}};
      kill_cnt_r    <= 4'd0;
      kill_active_r <= 1'b0;
      killed_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      kill_cnt_r    <= kill_cnt_nxt_s;
      kill_active_r <= (kill_cnt_nxt_s != 4'd0);
      killed_cnt_r  <= killed_nxt_s;
      if (flush_in) begin
        vld_r <= {NUM_CH{1'b0}};
      end else if (!stall_in) begin
        for (int i = 0; i < NUM_CH; i++) begin
          vld_r[i] <= wr_en_in[i] & kill_idle_s;
          // Address/data only move with a valid capture so the last write stays visible.
          if (wr_en_in[i] && kill_idle_s) begin
            addr_r[i*ADDR_W +: ADDR_W] <= wr_addr_in[i*ADDR_W +: ADDR_W];
            data_r[i*DATA_W +: DATA_W] <= wr_data_in[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_msrv32_wb_wr_en_pipe.sv
// Directed bench for msrv32_wb_wr_en_pipe: vector table for commit/stall/flush/kill
// behaviour plus a hand-written saturation sequence on a narrow-counter instance.
module tb_msrv32_wb_wr_en_pipe;

  localparam logic [11:0] JA0 = 12'hFFF;
  localparam logic [11:0] JA1 = 12'hEEE;
  localparam logic [31:0] JD0 = 32'hBAD0_0000;
  localparam logic [31:0] JD1 = 32'hBAD1_1111;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        st;
    logic [1:0]  en;
    logic [11:0] a0;
    logic [11:0] a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  e_en;
    logic [11:0] e_a0;
    logic [11:0] e_a1;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic        e_kact;
    logic [15:0] e_killed;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_in, flush_in, stall_in;
  logic [1:0]  wr_en_in;
  logic [23:0] wr_addr_in;
  logic [63:0] wr_data_in;
  logic [1:0]  wr_en_out, s_wr_en_out;
  logic [23:0] wr_addr_out, s_wr_addr_out;
  logic [63:0] wr_data_out, s_wr_data_out;
  logic        kill_active_out, s_kill_active_out;
  logic [15:0] killed_cnt_out;
  logic [3:0]  s_killed_cnt_out;

  int checks = 0;
  int failures = 0;
  vec_t tbl[21];

  always #5 clk = ~clk;

  msrv32_wb_wr_en_pipe dut (
    .clk_in(clk), .rst_in(rst_in), .flush_in(flush_in), .stall_in(stall_in),
    .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
    .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
    .kill_active_out(kill_active_out), .killed_cnt_out(killed_cnt_out)
  );

  msrv32_wb_wr_en_pipe #(.CNT_W(4)) dut_sat (
    .clk_in(clk), .rst_in(rst_in), .flush_in(flush_in), .stall_in(stall_in),
    .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
    .wr_en_out(s_wr_en_out), .wr_addr_out(s_wr_addr_out), .wr_data_out(s_wr_data_out),
    .kill_active_out(s_kill_active_out), .killed_cnt_out(s_killed_cnt_out)
  );

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h expected=%h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic s, input logic [1:0] e,
                       input logic [11:0] a0, input logic [11:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    rst_in     = r;
    flush_in   = f;
    stall_in   = s;
    wr_en_in   = e;
    wr_addr_in = {a1, a0};
    wr_data_in = {d1, d0};
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 2'b11, JA0, JA1, JD0, JD1);

    // rst fl st en   a0       a1       d0            d1            | en    a0       a1       d0            d1            kact  killed
    tbl[0]  = '{1'b1,1'b0,1'b0,2'b11,JA0,JA1,JD0,JD1,             2'b00,12'h000,12'h000,32'h0,32'h0,1'b0,16'd0};
    tbl[1]  = '{1'b1,1'b0,1'b0,2'b11,JA0,JA1,JD0,JD1,             2'b00,12'h000,12'h000,32'h0,32'h0,1'b0,16'd0};
    tbl[2]  = '{1'b0,1'b0,1'b0,2'b01,12'h005,JA1,32'hDEADBEEF,JD1, 2'b00,12'h000,12'h000,32'h0,32'h0,1'b0,16'd0};
    tbl[3]  = '{1'b0,1'b0,1'b0,2'b00,JA0,JA1,JD0,JD1,             2'b01,12'h005,12'h000,32'hDEADBEEF,32'h0,1'b0,16'd0};
    tbl[4]  = '{1'b0,1'b0,1'b0,2'b10,JA0,12'h300,JD0,32'hCAFE0001, 2'b00,12'h005,12'h000,32'hDEADBEEF,32'h0,1'b0,16'd0};
    tbl[5]  = '{1'b0,1'b0,1'b1,2'b11,JA0,JA1,JD0,JD1,             2'b00,12'h005,12'h300,32'hDEADBEEF,32'hCAFE0001,1'b0,16'd0};
    tbl[6]  = '{1'b0,1'b0,1'b1,2'b11,JA0,JA1,JD0,JD1,             2'b00,12'h005,12'h300,32'hDEADBEEF,32'hCAFE0001,1'b0,16'd0};
    tbl[7]  = '{1'b0,1'b0,1'b1,2'b11,JA0,JA1,JD0,JD1,             2'b00,12'h005,12'h300,32'hDEADBEEF,32'hCAFE0001,1'b0,16'd0};
    tbl[8]  = '{1'b0,1'b0,1'b0,2'b11,12'h010,12'h020,32'h10,32'h20, 2'b10,12'h005,12'h300,32'hDEADBEEF,32'hCAFE0001,1'b0,16'd0};
    tbl[9]  = '{1'b0,1'b1,1'b0,2'b11,JA0,JA1,JD0,JD1,             2'b00,12'h010,12'h020,32'h10,32'h20,1'b0,16'd0};
    tbl[10] = '{1'b0,1'b0,1'b0,2'b01,JA0,JA1,JD0,JD1,             2'b00,12'h010,12'h020,32'h10,32'h20,1'b1,16'd4};
    tbl[11] = '{1'b0,1'b0,1'b0,2'b00,JA0,JA1,JD0,JD1,             2'b00,12'h010,12'h020,32'h10,32'h20,1'b0,16'd5};
    tbl[12] = '{1'b0,1'b0,1'b0,2'b01,12'h040,JA1,32'h40,JD1,       2'b00,12'h010,12'h020,32'h10,32'h20,1'b0,16'd5};
    tbl[13] = '{1'b0,1'b0,1'b1,2'b00,JA0,JA1,JD0,JD1,             2'b00,12'h040,12'h020,32'h40,32'h20,1'b0,16'd5};
    tbl[14] = '{1'b0,1'b1,1'b1,2'b01,JA0,JA1,JD0,JD1,             2'b00,12'h040,12'h020,32'h40,32'h20,1'b0,16'd5};
    tbl[15] = '{1'b0,1'b0,1'b0,2'b00,JA0,JA1,JD0,JD1,             2'b00,12'h040,12'h020,32'h40,32'h20,1'b1,16'd6};
    tbl[16] = '{1'b0,1'b0,1'b0,2'b00,JA0,JA1,JD0,JD1,             2'b00,12'h040,12'h020,32'h40,32'h20,1'b0,16'd6};
    tbl[17] = '{1'b0,1'b1,1'b0,2'b00,JA0,JA1,JD0,JD1,             2'b00,12'h040,12'h020,32'h40,32'h20,1'b0,16'd6};
    tbl[18] = '{1'b0,1'b0,1'b1,2'b11,JA0,JA1,JD0,JD1,             2'b00,12'h040,12'h020,32'h40,32'h20,1'b1,16'd6};
    tbl[19] = '{1'b0,1'b0,1'b0,2'b11,12'h060,12'h050,32'h60,32'h50, 2'b00,12'h040,12'h020,32'h40,32'h20,1'b0,16'd6};
    tbl[20] = '{1'b0,1'b0,1'b0,2'b00,JA0,JA1,JD0,JD1,             2'b11,12'h060,12'h050,32'h60,32'h50,1'b0,16'd6};

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].fl, tbl[i].st, tbl[i].en, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      #2;
      chk("wr_en", i, {30'd0, wr_en_out}, {30'd0, tbl[i].e_en});
      chk("addr0", i, {20'd0, wr_addr_out[11:0]}, {20'd0, tbl[i].e_a0});
      chk("addr1", i, {20'd0, wr_addr_out[23:12]}, {20'd0, tbl[i].e_a1});
      chk("data0", i, wr_data_out[31:0], tbl[i].e_d0);
      chk("data1", i, wr_data_out[63:32], tbl[i].e_d1);
      chk("kill_active", i, {31'd0, kill_active_out}, {31'd0, tbl[i].e_kact});
      chk("killed_cnt", i, {16'd0, killed_cnt_out}, {16'd0, tbl[i].e_killed});
    end

    // Saturation: 10 flush cycles dropping two requests each = 20 killed writes.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 2'b11, JA0, JA1, JD0, JD1);
      #2;
      chk("flush_gate_en", 100 + k, {30'd0, wr_en_out}, 32'd0);
      if (k == 5) begin
        chk("sat_mid_wide", 100 + k, {16'd0, killed_cnt_out}, 32'd16);
        chk("sat_mid_narrow", 100 + k, {28'd0, s_killed_cnt_out}, 32'd15);
      end
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 2'b00, JA0, JA1, JD0, JD1);
    #2;
    chk("sat_end_wide", 200, {16'd0, killed_cnt_out}, 32'd26);
    chk("sat_end_narrow", 200, {28'd0, s_killed_cnt_out}, 32'd15);
    chk("sat_kill_active", 200, {31'd0, kill_active_out}, 32'd1);
    @(negedge clk);
    #2;
    chk("sat_hold_narrow", 201, {28'd0, s_killed_cnt_out}, 32'd15);
    chk("sat_kill_done", 201, {31'd0, kill_active_out}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
